// File: rtl/smvm_row_collector.sv
// Reassembles 12-bit SMVM result half-words into 24-bit row results and
// buffers them in a small FIFO with valid/ready output, row index and last flag.
module smvm_row_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ROW_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] rows_cfg,
  input  logic             in_valid,
  input  logic [11:0]      data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_data,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last,
  output logic             done,
  output logic             busy,
  output logic [1:0]       err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               half_q, half_d;
  logic [11:0]        hi_q, hi_d;
  logic [1:0]         err_q, err_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [23:0]        out_data_q, out_data_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [23:0]        mem_data_q [DEPTH];
  logic [ROW_W-1:0]   mem_row_q  [DEPTH];
  logic               mem_last_q [DEPTH];

  logic               push;
  logic               pop;
  logic               last_row;

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    row_d    = row_q;
    half_d   = half_q;
    hi_d     = hi_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pop      = out_valid_q && out_ready;
    last_row = (row_q == rows_q - ROW_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = rows_cfg;
          row_d   = '0;
          half_d  = 1'b0;
          err_d   = 2'b00;
          state_d = (rows_cfg == '0) ? S_DONE : S_COLLECT;
        end
        if (in_valid) err_d[1] = 1'b1;
      end
      S_COLLECT: begin
        if (in_valid) begin
          half_d = ~half_q;
          if (!half_q) begin
            hi_d = data_in;
          end else begin
            row_d = row_q + ROW_W'(1);
            // A pop in the same cycle frees the slot, so a full FIFO can still accept
            if ((cnt_q != CNT_W'(DEPTH)) || pop) push = 1'b1;
            else err_d[0] = 1'b1;
            if (last_row) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (in_valid) err_d[1] = 1'b1;
        // No pushes here, so the last entry (or nothing, if it was dropped) empties the FIFO
        if ((cnt_q == CNT_W'(0)) || (pop && (cnt_q == CNT_W'(1)))) state_d = S_DONE;
      end
      default: begin
        if (in_valid) err_d[1] = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    // Registered head: next head is either the entry being written now or stored data
    out_valid_d = (cnt_d != CNT_W'(0));
    if (cnt_d == CNT_W'(0)) begin
      out_data_d = '0;
      out_row_d  = '0;
      out_last_d = 1'b0;
    end else if (push && (rd_ptr_d == wr_ptr_q)) begin
      out_data_d = {hi_q, data_in};
      out_row_d  = row_q;
      out_last_d = last_row;
    end else begin
      out_data_d = mem_data_q[rd_ptr_d];
      out_row_d  = mem_row_q[rd_ptr_d];
      out_last_d = mem_last_q[rd_ptr_d];
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      row_q       <= '0;
      half_q      <= 1'b0;
      hi_q        <= '0;
      err_q       <= 2'b00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      row_q       <= row_d;
      half_q      <= half_d;
      hi_q        <= hi_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array needs no reset; occupancy and pointers define what is live
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data_q[wr_ptr_q] <= {hi_q, data_in};
      mem_row_q[wr_ptr_q]  <= row_q;
      mem_last_q[wr_ptr_q] <= last_row;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_smvm_row_collector.sv
// Directed bench for smvm_row_collector: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_smvm_row_collector;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned ROW_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ROW_W-1:0] rows_cfg;
  logic             in_valid;
  logic [11:0]      data_in;
  logic             out_valid;
  logic             out_ready;
  logic [23:0]      out_data;
  logic [ROW_W-1:0] out_row;
  logic             out_last;
  logic             done;
  logic             busy;
  logic [1:0]       err;

  int vectors = 0;
  int miscompares = 0;

  smvm_row_collector #(.DEPTH(DEPTH), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rows_cfg(rows_cfg),
    .in_valid(in_valid), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue of completed rows, phase as a plain integer
  typedef struct packed {
    logic [23:0]      d;
    logic [ROW_W-1:0] r;
    logic             l;
  } ent_t;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_DRAIN = 2, P_DONE = 3;

  ent_t             mq[$];
  int               ph = P_IDLE;
  int               m_rows = 0;
  int               m_row = 0;
  bit               m_half = 0;
  logic [11:0]      m_hi = '0;
  logic [1:0]       m_err = '0;
  bit               m_dropped = 0;
  bit               model_live = 0;

  always @(posedge clk) begin
    bit   m_pop, full_pre, popped_last;
    int   nph;
    ent_t e;
    full_pre = (mq.size() == DEPTH);
    m_pop    = (mq.size() != 0) && out_ready;
    if (rst) begin
      mq.delete();
      ph = P_IDLE; m_rows = 0; m_row = 0; m_half = 0; m_err = '0; m_dropped = 0;
      model_live = 1;
    end else begin
      nph = ph;
      popped_last = 0;
      if (m_pop) begin
        e = mq.pop_front();
        popped_last = e.l;
      end
      if (ph == P_IDLE && start) begin
        m_rows = int'(rows_cfg); m_row = 0; m_half = 0; m_err = '0; m_dropped = 0;
        nph = (rows_cfg == '0) ? P_DONE : P_COLLECT;
      end
      if (in_valid && ph != P_COLLECT) m_err[1] = 1'b1;
      if (ph == P_COLLECT && in_valid) begin
        if (!m_half) m_hi = data_in;
        else begin
          e.d = {m_hi, data_in};
          e.r = ROW_W'(m_row);
          e.l = (m_row == m_rows - 1);
          if (full_pre && !m_pop) begin
            m_err[0] = 1'b1;
            if (e.l) m_dropped = 1;
          end else mq.push_back(e);
          if (e.l) nph = P_DRAIN;
          m_row++;
        end
        m_half = !m_half;
      end
      if (ph == P_DRAIN && (popped_last || (m_dropped && mq.size() == 0))) nph = P_DONE;
      if (ph == P_DONE) nph = P_IDLE;
      ph = nph;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (model_live) begin
      logic exp_v, exp_busy, exp_done, bad;
      exp_v    = (mq.size() != 0);
      exp_busy = (ph != P_IDLE);
      exp_done = (ph == P_DONE);
      bad = (out_valid !== exp_v) || (busy !== exp_busy) || (done !== exp_done) || (err !== m_err);
      if (exp_v && !bad)
        bad = (out_data !== mq[0].d) || (out_row !== mq[0].r) || (out_last !== mq[0].l);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t: got v=%0b d=%h r=%0d l=%0b busy=%0b done=%0b err=%b; want v=%0b d=%h r=%0d l=%0b busy=%0b done=%0b err=%b",
                 $time, out_valid, out_data, out_row, out_last, busy, done, err,
                 exp_v, exp_v ? mq[0].d : 24'h0, exp_v ? mq[0].r : '0, exp_v ? mq[0].l : 1'b0,
                 exp_busy, exp_done, m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic word(input logic [11:0] d);
    in_valid = 1'b1;
    data_in  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int rc);
    start    = 1'b1;
    rows_cfg = ROW_W'(rc);
    step();
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rows_cfg = '0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);

    // Two rows streamed with a ready consumer
    out_ready = 1'b1;
    do_start(2);
    chk("s1_busy", 32'(busy), 32'd1);
    word(12'h012);
    chk("s1_v0_early", 32'(out_valid), 32'd0);
    word(12'h345);
    chk("s1_v0", 32'(out_valid), 32'd1);
    chk("s1_d0", 32'(out_data), 32'h012345);
    chk("s1_r0", 32'(out_row), 32'd0);
    chk("s1_l0", 32'(out_last), 32'd0);
    word(12'hABC);
    chk("s1_popped0", 32'(out_valid), 32'd0);
    word(12'hDEF);
    chk("s1_d1", 32'(out_data), 32'hABCDEF);
    chk("s1_r1", 32'(out_row), 32'd1);
    chk("s1_l1", 32'(out_last), 32'd1);
    step();
    chk("s1_done", 32'(done), 32'd1);
    step();
    chk("s1_done_once", 32'(done), 32'd0);
    chk("s1_idle", 32'(busy), 32'd0);

    // Zero rows completes immediately
    do_start(0);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_valid", 32'(out_valid), 32'd0);
    step();
    chk("s2_done_once", 32'(done), 32'd0);

    // Stray input while idle, cleared by start
    word(12'h111);
    chk("s3_err", 32'(err), 32'd2);
    chk("s3_valid", 32'(out_valid), 32'd0);
    do_start(1);
    chk("s3_err_clr", 32'(err), 32'd0);
    word(12'hAAA);
    word(12'h555);
    chk("s3_d", 32'(out_data), 32'hAAA555);
    chk("s3_l", 32'(out_last), 32'd1);
    step();
    chk("s3_done", 32'(done), 32'd1);
    step();

    // Overflow: 10 rows into an 8-deep FIFO with consumer stalled
    out_ready = 1'b0;
    do_start(10);
    for (int r = 0; r < 10; r++) begin
      word(12'h100 + 12'(r));
      word(12'h200 + 12'(r));
    end
    chk("s4_err", 32'(err), 32'd1);
    chk("s4_busy", 32'(busy), 32'd1);
    chk("s4_done_held", 32'(done), 32'd0);
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk("s4_head_d", 32'(out_data), {8'h00, 12'h100 + 12'(r), 12'h200 + 12'(r)});
      chk("s4_head_r", 32'(out_row), 32'(r));
      chk("s4_head_l", 32'(out_last), 32'd0);
      step();
    end
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_err_sticky", 32'(err), 32'd1);
    step();

    // Full FIFO: second half arrives together with a pop
    out_ready = 1'b0;
    do_start(10);
    for (int r = 0; r < 8; r++) begin
      word(12'h300 + 12'(r));
      word(12'h400 + 12'(r));
    end
    word(12'h308);
    out_ready = 1'b1;
    word(12'h408);
    chk("s5_err", 32'(err), 32'd0);
    chk("s5_head_r", 32'(out_row), 32'd1);
    word(12'h309);
    word(12'h409);
    begin
      int i;
      i = 0;
      while (!(out_valid && out_last) && i < 40) begin
        step();
        i++;
      end
    end
    chk("s5_last_seen", 32'(out_valid && out_last), 32'd1);
    chk("s5_last_r", 32'(out_row), 32'd9);
    chk("s5_last_d", 32'(out_data), 32'h309409);
    step();
    chk("s5_done", 32'(done), 32'd1);
    chk("s5_err_end", 32'(err), 32'd0);
    step();

    // Reset mid-collection, then a fresh single-row run
    out_ready = 1'b0;
    do_start(2);
    word(12'h012);
    word(12'h345);
    word(12'hABC);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_err", 32'(err), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
    out_ready = 1'b1;
    do_start(1);
    word(12'h777);
    word(12'h888);
    chk("s6_d", 32'(out_data), 32'h777888);
    chk("s6_r", 32'(out_row), 32'd0);
    chk("s6_l", 32'(out_last), 32'd1);
    step();
    chk("s6_done_pulse", 32'(done), 32'd1);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
